gcd_driver: RTL and testbench
=============================

Name: gcd_driver

Overview:
- Request-side initiator for the GCD accelerator: buffers operand pairs with expected results, issues them over the GCD valid/ready input port, and waits for each result.
- Compares every result against its expected value and keeps pass/fail/timeout status.
- Used as the on-chip stimulus and checker for GCD self-test; the consumer of gcd_out_* and the producer of gcd_in_*.

Parameters:
- W, 16, operand and result width; gcd_in_data is 2*W.
- DEPTH, 8, number of buffered test vectors (power of two).
- TIMEOUT, 1024, maximum cycles to wait for a result after issue.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  a test vector is presented.
- load_ready  out  1  the buffer accepts a vector.
- load_a  in  W  operand A.
- load_b  in  W  operand B.
- load_exp  in  W  expected GCD.
- start  in  1  begin (or replay) the run; single-cycle pulse.
- clear  in  1  empty the buffer and return to IDLE.
- busy  out  1  high in ISSUE or WAIT.
- done  out  1  high while in DONE.
- pass_count  out  $clog2(DEPTH)+1  results matching expected.
- fail_count  out  $clog2(DEPTH)+1  mismatches plus timeouts.
- timeout  out  1  sticky; set if any vector timed out.
- last_result  out  W  most recently captured gcd_out_data.
- gcd_in_valid  out  1  request valid.
- gcd_in_data  out  2W  {A, B}; A occupies bits [2W-1:W].
- gcd_in_ready  in  1  GCD accepts the request.
- gcd_out_valid  in  1  GCD result valid.
- gcd_out_data  in  W  GCD result.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE; count, rd_ptr, wr_ptr, pass_count, fail_count, timer, timeout, last_result=0; gcd_in_valid=0; gcd_in_data=0; done=0; busy=0. Buffer RAM contents are not reset.
- Reset mid-run aborts immediately: gcd_in_valid drops asynchronously, and any in-flight GCD result is ignored.
- Load: load_ready = (state==IDLE) && (count<DEPTH).
  - On load_valid && load_ready, the vector is written at wr_ptr; wr_ptr and count increment.
  - With count==DEPTH, load_ready=0 and no write occurs.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start with count>0 -> ISSUE next cycle; rd_ptr=0, pass_count=fail_count=0, timeout=0.
  - start with count==0 -> DONE with zero counts.
  - If start and load_valid coincide, the load completes first and the new vector counts toward the run.
- ISSUE:
  - gcd_in_valid=1 and gcd_in_data={a[rd_ptr], b[rd_ptr]}.
  - Data is held stable until gcd_in_valid && gcd_in_ready.
  - On handshake -> WAIT, timer=0; gcd_in_valid=0 from the next cycle.
  - Latency from start to first gcd_in_valid: 1 cycle.
- WAIT:
  - The first cycle with gcd_out_valid=1 captures gcd_out_data into last_result.
  - If equal to exp[rd_ptr], pass_count++; otherwise fail_count++.
  - Otherwise timer++. When timer reaches TIMEOUT-1 without a result: fail_count++, timeout=1, last_result unchanged.
  - After capture or timeout: if rd_ptr==count-1 -> DONE, else rd_ptr++ -> ISSUE.
  - gcd_out_valid in any state other than WAIT is ignored.
- DONE:
  - done=1; counts are held.
  - start -> replays the buffer (count retained) exactly as from IDLE.
  - clear -> IDLE with count=wr_ptr=0.
- clear in IDLE empties the buffer. clear in ISSUE/WAIT is ignored.
- If start and clear arrive together, clear wins.
- Counters never wrap: at most DEPTH increments per run.
- busy = (state==ISSUE || state==WAIT).

Test Plan:
- Load (0x0030,0x0020,exp 0x0010); start; GCD always ready, result after 10 cycles -> one request with gcd_in_data=0x00300020; pass_count=1, fail_count=0, done=1, last_result=0x0010.
- Load 3 vectors, second with wrong exp (48,18,exp 5) -> pass_count=2, fail_count=1, timeout=0; requests issued in load order.
- Hold gcd_in_ready=0 for 7 cycles -> gcd_in_valid stays 1 and gcd_in_data unchanged for all 7 cycles; request accepted on cycle 8.
- TIMEOUT=16 with gcd_out_valid held 0 -> fail_count=1 and timeout=1 at cycle 16 after handshake; then advances to the next vector or to DONE.
- Load 9 vectors with DEPTH=8 -> load_ready=0 after 8 accepts; 9th not stored; run yields pass_count+fail_count=8. Then start in DONE replays and clear returns to IDLE with load_ready=1.
- Assert rst during WAIT, then load 1 vector and start -> all outputs zero; stale gcd_out_valid ignored; the new run completes with pass_count=1.

Source files
------------

// File: rtl/gcd_driver_if.sv
// Valid/ready request and result channel between the self-test driver and the GCD accelerator.
interface gcd_driver_if #(
  parameter int W = 16
);
  logic           gcd_in_valid;
  logic [2*W-1:0] gcd_in_data;
  logic           gcd_in_ready;
  logic           gcd_out_valid;
  logic [W-1:0]   gcd_out_data;

  // The driver issues requests and consumes results.
  modport master (
    output gcd_in_valid, gcd_in_data,
    input  gcd_in_ready, gcd_out_valid, gcd_out_data
  );

  // The accelerator accepts requests and produces results.
  modport slave (
    input  gcd_in_valid, gcd_in_data,
    output gcd_in_ready, gcd_out_valid, gcd_out_data
  );
endinterface

// File: rtl/gcd_driver.sv
// GCD self-test driver: buffers operand/expected triples, issues them one at a time
// and scores each result against its expected value.
//
// state | meaning
// IDLE  | buffer may be loaded; waiting for start
// ISSUE | request for vector rd_ptr is presented on gcd_in_*
// WAIT  | request accepted; waiting for the result or a timeout
// DONE  | run finished; counts held until start (replay) or clear
module gcd_driver #(
  parameter int W       = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_a,
  input  logic [W-1:0]  load_b,
  input  logic [W-1:0]  load_exp,
  input  logic          start,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic          timeout,
  output logic [W-1:0]  last_result,
  gcd_driver_if.master  gcd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [TW-1:0]  timer;

  logic [W-1:0]   a_mem [DEPTH];
  logic [W-1:0]   b_mem [DEPTH];
  logic [W-1:0]   e_mem [DEPTH];

  logic           load_fire;
  logic [CW-1:0]  cnt_eff;
  logic [PW-1:0]  rd_next;
  logic           last_vec;
  logic           timer_end;
  logic           wait_end;
  logic [2*W-1:0] first_data;
  logic [2*W-1:0] next_data;

  assign load_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign load_fire  = load_valid && load_ready;
  // A load coinciding with start belongs to the run being started.
  assign cnt_eff    = count + CW'(load_fire);
  assign rd_next    = rd_ptr + PW'(1);
  assign last_vec   = (CW'(rd_ptr) == count - CW'(1));
  assign timer_end  = (timer == TW'(TIMEOUT - 1));
  assign wait_end   = gcd.gcd_out_valid || timer_end;
  // Vector 0 may be written on the same edge the run starts, so bypass the RAM then.
  assign first_data = (load_fire && (wr_ptr == '0)) ? {load_a, load_b} : {a_mem[0], b_mem[0]};
  assign next_data  = {a_mem[rd_next], b_mem[rd_next]};

  // Vector buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      a_mem[wr_ptr] <= load_a;
      b_mem[wr_ptr] <= load_b;
      e_mem[wr_ptr] <= load_exp;
    end
  end

  // Sequencer, scoreboard and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      timer            <= '0;
      timeout          <= 1'b0;
      last_result      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      gcd.gcd_in_valid <= 1'b0;
      gcd.gcd_in_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (clear) begin
            count  <= '0;
            wr_ptr <= '0;
            done   <= 1'b0;
            state  <= IDLE;
          end else begin
            if (load_fire) begin
              wr_ptr <= wr_ptr + PW'(1);
              count  <= count + CW'(1);
            end
            if (start) begin
              rd_ptr     <= '0;
              pass_count <= '0;
              fail_count <= '0;
              timeout    <= 1'b0;
              if (cnt_eff != '0) begin
                state            <= ISSUE;
                busy             <= 1'b1;
                done             <= 1'b0;
                gcd.gcd_in_valid <= 1'b1;
                gcd.gcd_in_data  <= first_data;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (gcd.gcd_in_ready) begin
            gcd.gcd_in_valid <= 1'b0;
            timer            <= '0;
            state            <= WAIT;
          end
        end
        WAIT: begin
          if (gcd.gcd_out_valid) begin
            last_result <= gcd.gcd_out_data;
            if (gcd.gcd_out_data == e_mem[rd_ptr]) pass_count <= pass_count + CW'(1);
            else                                   fail_count <= fail_count + CW'(1);
          end else if (timer_end) begin
            fail_count <= fail_count + CW'(1);
            timeout    <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
          if (wait_end) begin
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_ptr           <= rd_next;
              state            <= ISSUE;
              gcd.gcd_in_valid <= 1'b1;
              gcd.gcd_in_data  <= next_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver; the bench plays the GCD accelerator with fixed answers.
module tb_gcd_driver;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_ready;
  logic [15:0] load_a, load_b, load_exp;
  logic        start, clear, busy, done, timeout;
  logic [3:0]  pass_count, fail_count;
  logic [15:0] last_result;

  int compared   = 0;
  int mismatched = 0;

  gcd_driver_if #(.W(W)) gif ();

  gcd_driver #(.W(W), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_a(load_a), .load_b(load_b), .load_exp(load_exp),
    .start(start), .clear(clear), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count),
    .timeout(timeout), .last_result(last_result),
    .gcd(gif)
  );

  always #5 clk = ~clk;

  task automatic load_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e, output bit acc);
    load_valid = 1'b1; load_a = a; load_b = b; load_exp = e;
    #1 acc = load_ready;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Accelerator stand-in: accept one request after rdy_delay stalled cycles, answer after lat cycles (lat<0: never).
  task automatic serve(input int rdy_delay, input int lat, input logic [15:0] res,
                       output bit seen, output logic [31:0] req, output bit stable);
    int n = 0;
    while (!gif.gcd_in_valid && n < 100) begin @(negedge clk); n++; end
    seen = gif.gcd_in_valid;
    req = gif.gcd_in_data;
    stable = 1'b1;
    if (seen) begin
      for (int i = 0; i < rdy_delay; i++) begin
        @(negedge clk);
        if (!gif.gcd_in_valid || gif.gcd_in_data !== req) stable = 1'b0;
      end
      gif.gcd_in_ready = 1'b1;
      @(negedge clk);
      gif.gcd_in_ready = 1'b0;
      if (lat >= 0) begin
        repeat (lat) @(negedge clk);
        gif.gcd_out_valid = 1'b1; gif.gcd_out_data = res;
        @(negedge clk);
        gif.gcd_out_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    compared++;
    if (done !== 1'b1) begin mismatched++; $display("FAIL %s done_wait: done=%b after %0d cycles, want 1", name, done, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({load_ready, busy, done, timeout, gif.gcd_in_valid} !== 5'b10000) begin
      mismatched++; $display("FAIL reset_flags: got %b want 10000", {load_ready, busy, done, timeout, gif.gcd_in_valid});
    end
    compared++;
    if ({pass_count, fail_count, last_result, gif.gcd_in_data} !== '0) begin
      mismatched++; $display("FAIL reset_values: pass=%0d fail=%0d last=%h data=%h want all 0", pass_count, fail_count, last_result, gif.gcd_in_data);
    end
    rst = 1'b0;
    @(negedge clk);
    do_start();
    compared++;
    if ({done, busy, pass_count, fail_count, gif.gcd_in_valid} !== {2'b10, 8'd0, 1'b0}) begin
      mismatched++; $display("FAIL empty_start: done=%b busy=%b pass=%0d fail=%0d valid=%b want done only", done, busy, pass_count, fail_count, gif.gcd_in_valid);
    end
    do_clear();
    compared++;
    if ({done, load_ready} !== 2'b01) begin mismatched++; $display("FAIL empty_clear: done=%b load_ready=%b want 0 1", done, load_ready); end
  endtask

  task automatic test_single();
    bit acc, seen, stable; logic [31:0] req;
    load_vec(16'h0030, 16'h0020, 16'h0010, acc);
    do_start();
    compared++;
    if ({gif.gcd_in_valid, busy} !== 2'b11) begin mismatched++; $display("FAIL single_latency: valid=%b busy=%b want 1 1", gif.gcd_in_valid, busy); end
    serve(0, 10, 16'h0010, seen, req, stable);
    compared++;
    if (req !== 32'h00300020) begin mismatched++; $display("FAIL single_req: got %h want 00300020", req); end
    wait_done("single");
    compared++;
    if ({pass_count, fail_count, last_result, busy} !== {4'd1, 4'd0, 16'h0010, 1'b0}) begin
      mismatched++; $display("FAIL single_result: pass=%0d fail=%0d last=%h busy=%b want 1 0 0010 0", pass_count, fail_count, last_result, busy);
    end
  endtask

  task automatic test_mixed();
    logic [15:0] va [3] = '{16'd12, 16'd48, 16'd35};
    logic [15:0] vb [3] = '{16'd8, 16'd18, 16'd21};
    logic [15:0] ve [3] = '{16'd4, 16'd5, 16'd7};
    logic [15:0] vr [3] = '{16'd4, 16'd6, 16'd7};
    logic [31:0] vq [3] = '{32'h000c0008, 32'h00300012, 32'h00230015};
    bit acc, seen, stable; logic [31:0] req;
    do_clear();
    for (int i = 0; i < 3; i++) load_vec(va[i], vb[i], ve[i], acc);
    do_start();
    for (int i = 0; i < 3; i++) begin
      serve(0, 2, vr[i], seen, req, stable);
      compared++;
      if (req !== vq[i]) begin mismatched++; $display("FAIL mixed_req%0d: got %h want %h", i, req, vq[i]); end
    end
    wait_done("mixed");
    compared++;
    if ({pass_count, fail_count, timeout, last_result} !== {4'd2, 4'd1, 1'b0, 16'd7}) begin
      mismatched++; $display("FAIL mixed_result: pass=%0d fail=%0d to=%b last=%h want 2 1 0 0007", pass_count, fail_count, timeout, last_result);
    end
  endtask

  task automatic test_backpressure();
    bit acc, seen, stable; logic [31:0] req;
    do_clear();
    load_vec(16'h0015, 16'h000e, 16'h0007, acc);
    do_start();
    serve(7, 1, 16'h0007, seen, req, stable);
    compared++;
    if ({seen, stable} !== 2'b11 || req !== 32'h0015000e) begin
      mismatched++; $display("FAIL bp_hold: seen=%b stable=%b data=%h want 1 1 0015000e", seen, stable, req);
    end
    wait_done("bp");
    compared++;
    if ({pass_count, fail_count} !== {4'd1, 4'd0}) begin mismatched++; $display("FAIL bp_result: pass=%0d fail=%0d want 1 0", pass_count, fail_count); end
  endtask

  task automatic test_timeout();
    bit acc, seen, stable; logic [31:0] req;
    do_clear();
    load_vec(16'd9, 16'd6, 16'd3, acc);
    load_vec(16'd10, 16'd4, 16'd2, acc);
    do_start();
    serve(0, -1, 16'h0, seen, req, stable);
    compared++;
    if ({gif.gcd_in_valid, busy} !== 2'b01) begin mismatched++; $display("FAIL to_handshake: valid=%b busy=%b want 0 1", gif.gcd_in_valid, busy); end
    repeat (15) @(negedge clk);
    compared++;
    if ({timeout, fail_count} !== {1'b0, 4'd0}) begin mismatched++; $display("FAIL to_early: to=%b fail=%0d at cycle 15 want 0 0", timeout, fail_count); end
    @(negedge clk);
    compared++;
    if ({timeout, fail_count, last_result} !== {1'b1, 4'd1, 16'h0007}) begin
      mismatched++; $display("FAIL to_fire: to=%b fail=%0d last=%h at cycle 16 want 1 1 0007", timeout, fail_count, last_result);
    end
    compared++;
    if ({gif.gcd_in_valid, gif.gcd_in_data} !== {1'b1, 32'h000a0004}) begin
      mismatched++; $display("FAIL to_advance: valid=%b data=%h want 1 000a0004", gif.gcd_in_valid, gif.gcd_in_data);
    end
    serve(0, 0, 16'd2, seen, req, stable);
    wait_done("timeout");
    compared++;
    if ({pass_count, fail_count, timeout, last_result} !== {4'd1, 4'd1, 1'b1, 16'd2}) begin
      mismatched++; $display("FAIL to_result: pass=%0d fail=%0d to=%b last=%h want 1 1 1 0002", pass_count, fail_count, timeout, last_result);
    end
  endtask

  task automatic test_full_replay();
    bit acc, seen, stable; logic [31:0] req;
    int accepted = 0;
    do_clear();
    for (int k = 1; k <= 8; k++) begin
      load_vec(16'(6 * k), 16'(4 * k), 16'(2 * k), acc);
      if (acc) accepted++;
    end
    compared++;
    if (accepted != 8 || load_ready !== 1'b0) begin mismatched++; $display("FAIL full_accept: accepted=%0d load_ready=%b want 8 0", accepted, load_ready); end
    load_vec(16'd100, 16'd75, 16'd25, acc);
    compared++;
    if (acc !== 1'b0) begin mismatched++; $display("FAIL full_ninth: accepted=%b want 0", acc); end
    for (int run = 0; run < 2; run++) begin
      do_start();
      for (int k = 1; k <= 8; k++) begin
        serve(0, 1, 16'(2 * k), seen, req, stable);
        compared++;
        if (req !== {16'(6 * k), 16'(4 * k)}) begin mismatched++; $display("FAIL full_req run%0d v%0d: got %h want %h", run, k, req, {16'(6 * k), 16'(4 * k)}); end
      end
      wait_done("full");
      repeat (3) @(negedge clk);
      compared++;
      if ({pass_count, fail_count, gif.gcd_in_valid, last_result} !== {4'd8, 4'd0, 1'b0, 16'd16}) begin
        mismatched++; $display("FAIL full_result run%0d: pass=%0d fail=%0d valid=%b last=%h want 8 0 0 0010", run, pass_count, fail_count, gif.gcd_in_valid, last_result);
      end
    end
    do_clear();
    compared++;
    if ({done, load_ready, busy} !== 3'b010) begin mismatched++; $display("FAIL full_clear: done=%b load_ready=%b busy=%b want 0 1 0", done, load_ready, busy); end
  endtask

  task automatic test_reset_midrun();
    bit acc, seen, stable; logic [31:0] req;
    load_vec(16'h0030, 16'h0020, 16'h0010, acc);
    do_start();
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({gif.gcd_in_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL rst_issue_async: valid=%b busy=%b want 0 0", gif.gcd_in_valid, busy); end
    @(negedge clk);
    rst = 1'b0;
    load_vec(16'h0030, 16'h0020, 16'h0010, acc);
    do_start();
    serve(0, -1, 16'h0, seen, req, stable);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if ({busy, done, timeout, gif.gcd_in_valid, pass_count, fail_count, last_result, gif.gcd_in_data} !== '0 || load_ready !== 1'b1) begin
      mismatched++; $display("FAIL rst_wait: busy=%b done=%b pass=%0d fail=%0d last=%h data=%h ready=%b want all 0, ready 1",
                             busy, done, pass_count, fail_count, last_result, gif.gcd_in_data, load_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    gif.gcd_out_valid = 1'b1; gif.gcd_out_data = 16'h0010;
    repeat (2) @(negedge clk);
    gif.gcd_out_valid = 1'b0;
    compared++;
    if ({pass_count, fail_count, last_result, done} !== '0) begin
      mismatched++; $display("FAIL rst_stale: pass=%0d fail=%0d last=%h done=%b want 0", pass_count, fail_count, last_result, done);
    end
    load_vec(16'h001b, 16'h0012, 16'h0009, acc);
    do_start();
    serve(0, 3, 16'h0009, seen, req, stable);
    wait_done("rst_rerun");
    compared++;
    if ({req, pass_count, fail_count, last_result} !== {32'h001b0012, 4'd1, 4'd0, 16'h0009}) begin
      mismatched++; $display("FAIL rst_rerun: req=%h pass=%0d fail=%0d last=%h want 001b0012 1 0 0009", req, pass_count, fail_count, last_result);
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_a = '0; load_b = '0; load_exp = '0;
    start = 1'b0; clear = 1'b0;
    gif.gcd_in_ready = 1'b0; gif.gcd_out_valid = 1'b0; gif.gcd_out_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_mixed();
    test_backpressure();
    test_timeout();
    test_full_replay();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, want completion");
    $fatal(1);
  end
endmodule
